// File: rtl/tl_traffic_model.sv
// Behavioural intersection model: per-lane car queues driven by the controller's light codes,
// occupancy sensors back to the controller, and sticky flags for unsafe light sequences.
module tl_traffic_model #(
    parameter int unsigned CNT_W      = 4,
    parameter int unsigned DEPART_CYC = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       La,
    input  logic [1:0]       Lb,
    input  logic             arr_a,
    input  logic             arr_b,
    input  logic             arr_al,
    input  logic             arr_bl,
    output logic             Ta,
    output logic             Tb,
    output logic             Tal,
    output logic             Tbl,
    output logic [CNT_W-1:0] q_a,
    output logic [CNT_W-1:0] q_b,
    output logic [CNT_W-1:0] q_al,
    output logic [CNT_W-1:0] q_bl,
    output logic [3:0]       ovf,
    output logic             err_conflict,
    output logic             err_seq
);

    localparam logic [1:0]       GREEN    = 2'b00;
    localparam logic [1:0]       YELLOW   = 2'b01;
    localparam logic [1:0]       LEFT     = 2'b10;
    localparam logic [1:0]       RED      = 2'b11;
    localparam logic [CNT_W-1:0] QMAX     = '1;
    localparam logic [3:0]       TMR_LAST = 4'(DEPART_CYC - 1);

    // Lane index order matches ovf: 0=a, 1=b, 2=al, 3=bl.
    logic [CNT_W-1:0] q_q   [4];
    logic [CNT_W-1:0] q_d   [4];
    logic [3:0]       tmr_q [4];
    logic [3:0]       tmr_d [4];
    logic [3:0]       ovf_q, ovf_d;
    logic             conflict_q, conflict_d;
    logic             seq_q, seq_d;
    logic [1:0]       prev_a_q, prev_b_q;
    logic [3:0]       perm, arr, dep;

    function automatic logic seq_legal(input logic [1:0] prev, input logic [1:0] cur);
        logic ok;
        case ({prev, cur})
            {GREEN, YELLOW}, {YELLOW, RED}, {YELLOW, LEFT},
            {LEFT, YELLOW}, {RED, GREEN}, {RED, LEFT}: ok = 1'b1;
            default:                                   ok = (prev == cur);
        endcase
        return ok;
    endfunction

    always_comb begin
        perm       = {Lb == LEFT, La == LEFT, Lb == GREEN, La == GREEN};
        arr        = {arr_bl, arr_al, arr_b, arr_a};
        dep        = '0;
        ovf_d      = ovf_q;
        for (int i = 0; i < 4; i++) begin
            q_d[i]   = q_q[i];
            tmr_d[i] = '0;
            // Timer only runs while there is a car to discharge, so departure can't underflow.
            dep[i]   = perm[i] && (q_q[i] != '0) && (tmr_q[i] == TMR_LAST);
            if (perm[i] && (q_q[i] != '0) && !dep[i]) begin
                tmr_d[i] = tmr_q[i] + 4'd1;
            end
            if (arr[i] && !dep[i]) begin
                if (q_q[i] == QMAX) begin
                    ovf_d[i] = 1'b1;
                end else begin
                    q_d[i] = q_q[i] + 1'b1;
                end
            end else if (!arr[i] && dep[i]) begin
                q_d[i] = q_q[i] - 1'b1;
            end
        end
        conflict_d = conflict_q | ((La != RED) && (Lb != RED));
        seq_d      = seq_q | !seq_legal(prev_a_q, La) | !seq_legal(prev_b_q, Lb);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                q_q[i]   <= '0;
                tmr_q[i] <= '0;
            end
            ovf_q      <= '0;
            conflict_q <= 1'b0;
            seq_q      <= 1'b0;
            prev_a_q   <= RED;
            prev_b_q   <= RED;
        end else begin
            for (int i = 0; i < 4; i++) begin
                q_q[i]   <= q_d[i];
                tmr_q[i] <= tmr_d[i];
            end
            ovf_q      <= ovf_d;
            conflict_q <= conflict_d;
            seq_q      <= seq_d;
            prev_a_q   <= La;
            prev_b_q   <= Lb;
        end
    end

    assign q_a          = q_q[0];
    assign q_b          = q_q[1];
    assign q_al         = q_q[2];
    assign q_bl         = q_q[3];
    assign Ta           = (q_q[0] != '0);
    assign Tb           = (q_q[1] != '0);
    assign Tal          = (q_q[2] != '0);
    assign Tbl          = (q_q[3] != '0);
    assign ovf          = ovf_q;
    assign err_conflict = conflict_q;
    assign err_seq      = seq_q;

endmodule
